// File: rtl/hog_ram_pkg.sv
// Shared definitions for the multi-bank RAM: clear-engine state encoding
// and default parameter values used by ram_nbank and its bank sub-module.
package hog_ram_pkg;

    localparam int DEF_NBANK   = 4;
    localparam int DEF_DW      = 8;
    localparam int DEF_AW      = 13;
    localparam int DEF_OUT_REG = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/ram_nbank_bank.sv
// Single simple-dual-port bank: one write port, one registered read port,
// read-first on a same-address collision.
module ram_nbank_bank
    import hog_ram_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_q_p0;

    // Write port; storage carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; the old word is sampled before a same-edge write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q_p0 <= '0;
        end else if (re) begin
            rd_q_p0 <= mem[raddr];
        end
    end

    assign rdata = rd_q_p0;

endmodule

// File: rtl/ram_nbank.sv
// NBANK independent SDP banks sharing one clock, one read strobe, one
// zero-fill clear engine and one read-valid pipeline.
module ram_nbank
    import hog_ram_pkg::*;
#(
    parameter int NBANK   = DEF_NBANK,
    parameter int DW      = DEF_DW,
    parameter int AW      = DEF_AW,
    parameter int OUT_REG = DEF_OUT_REG
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NBANK-1:0]    wr_en,
    input  logic [NBANK*AW-1:0] wr_addr,
    input  logic [NBANK*DW-1:0] wr_data,
    input  logic                rd_en,
    input  logic [NBANK*AW-1:0] rd_addr,
    output logic [NBANK*DW-1:0] rd_data,
    output logic                rd_valid,
    input  logic                clr,
    output logic                busy
);

    localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};

    clr_state_t          state;
    clr_state_t          state_nxt;
    logic [AW-1:0]       cnt;
    logic                init_pend;
    logic                rd_acc;
    logic                vld_p0;
    logic [NBANK*DW-1:0] bank_q;

    assign busy   = (state == CLEAR);
    assign rd_acc = rd_en & ~busy;

    // Clear engine registers; init_pend forces a clear on the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            init_pend <= 1'b1;
        end else begin
            state     <= state_nxt;
            init_pend <= 1'b0;
            cnt       <= (state == CLEAR) ? cnt + 1'b1 : '0;
        end
    end

    // Next state: enter CLEAR on request or after reset, leave once the last word is zeroed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr || init_pend) state_nxt = CLEAR;
            CLEAR:   if (cnt == CNT_LAST)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // First read-valid stage, aligned with the bank read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= rd_acc;
        end
    end

    // While clearing, every bank's write port is taken over by the zero-fill.
    for (genvar k = 0; k < NBANK; k++) begin : g_bank
        ram_nbank_bank #(
            .DW (DW),
            .AW (AW)
        ) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (busy | wr_en[k]),
            .waddr (busy ? cnt : wr_addr[k*AW +: AW]),
            .wdata (busy ? '0 : wr_data[k*DW +: DW]),
            .re    (rd_acc),
            .raddr (rd_addr[k*AW +: AW]),
            .rdata (bank_q[k*DW +: DW])
        );
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                vld_p1;
        logic [NBANK*DW-1:0] rd_data_p1;

        // Extra output stage; loads only when a read completes so data holds otherwise.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p1     <= 1'b0;
                rd_data_p1 <= '0;
            end else begin
                vld_p1 <= vld_p0;
                if (vld_p0) begin
                    rd_data_p1 <= bank_q;
                end
            end
        end

        assign rd_data  = rd_data_p1;
        assign rd_valid = vld_p1;
    end else begin : g_no_out_reg
        assign rd_data  = bank_q;
        assign rd_valid = vld_p0;
    end

endmodule

// File: tb/tb_ram_nbank.sv
// Bench for ram_nbank: two instances (read latency 1 and 2) share stimulus;
// a queue/array reference model predicts busy, rd_valid and rd_data.
module tb_ram_nbank;

    localparam int NB    = 4;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NB-1:0]     wr_en = '0;
    logic [NB*AW-1:0]  wr_addr = '0;
    logic [NB*DW-1:0]  wr_data = '0;
    logic              rd_en = 1'b0;
    logic [NB*AW-1:0]  rd_addr = '0;
    logic              clr = 1'b0;
    logic [NB*DW-1:0]  rd_data1, rd_data2;
    logic              rd_valid1, rd_valid2, busy1, busy2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_nbank #(.NBANK(NB), .DW(DW), .AW(AW), .OUT_REG(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .clr(clr), .busy(busy1));

    ram_nbank #(.NBANK(NB), .DW(DW), .AW(AW), .OUT_REG(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2), .rd_valid(rd_valid2),
        .clr(clr), .busy(busy2));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int due; logic [NB*DW-1:0] data; } rd_t;

    logic [DW-1:0]    mm [NB][DEPTH];
    int               busy_left = 0;
    bit               init_pend = 1'b1;
    int               ecnt = 0;
    rd_t              q1[$];
    rd_t              q2[$];
    logic [NB*DW-1:0] exp_d1 = '0, exp_d2 = '0;
    bit               exp_v1 = 1'b0, exp_v2 = 1'b0;

    always @(negedge rst_n) begin
        busy_left = 0;
        init_pend = 1'b1;
        q1.delete();
        q2.delete();
        exp_d1 = '0; exp_d2 = '0;
        exp_v1 = 1'b0; exp_v2 = 1'b0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            rd_t r;
            ecnt++;
            if (busy_left > 0) begin
                busy_left--;
            end else begin
                if (rd_en) begin
                    r.data = '0;
                    for (int k = 0; k < NB; k++) r.data[k*DW +: DW] = mm[k][rd_addr[k*AW +: AW]];
                    r.due = ecnt;     q1.push_back(r);
                    r.due = ecnt + 1; q2.push_back(r);
                end
                for (int k = 0; k < NB; k++)
                    if (wr_en[k]) mm[k][wr_addr[k*AW +: AW]] = wr_data[k*DW +: DW];
                if (clr || init_pend) begin
                    for (int k = 0; k < NB; k++)
                        for (int a = 0; a < DEPTH; a++) mm[k][a] = '0;
                    busy_left = DEPTH;
                    init_pend = 1'b0;
                end
            end
            exp_v1 = 1'b0;
            if (q1.size() > 0 && q1[0].due == ecnt) begin exp_v1 = 1'b1; exp_d1 = q1[0].data; q1.delete(0); end
            exp_v2 = 1'b0;
            if (q2.size() > 0 && q2[0].due == ecnt) begin exp_v2 = 1'b1; exp_d2 = q2[0].data; q2.delete(0); end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(posedge clk) begin
        #1;
        chk("busy_lat1", busy1, busy_left > 0);
        chk("busy_lat2", busy2, busy_left > 0);
        chk("valid_lat1", rd_valid1, exp_v1);
        chk("valid_lat2", rd_valid2, exp_v2);
        chk("data_lat1", rd_data1, exp_d1);
        chk("data_lat2", rd_data2, exp_d2);
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        wr_en = '0; rd_en = 1'b0; clr = 1'b0;
    endtask

    // Caller sits on a negedge where busy has just risen; counts busy cycles.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            if (busy2) n++;
            else break;
            @(negedge clk);
        end
    endtask

    task automatic read_range(input int start, input int n, output int vcnt);
        vcnt = 0;
        for (int i = 0; i < n + 3; i++) begin
            if (i < n) begin
                rd_en = 1'b1;
                for (int k = 0; k < NB; k++) rd_addr[k*AW +: AW] = AW'(start + i);
            end else begin
                rd_en = 1'b0;
            end
            @(negedge clk);
            if (rd_valid2) vcnt++;
        end
    endtask

    int n, vc;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_busy", busy2, 0);
        chk("reset_valid", rd_valid2, 0);
        chk("reset_data", rd_data2, 0);

        // Power-on clear.
        rst_n = 1'b1;
        @(negedge clk);
        chk("busy_first_edge", busy2, 1);
        count_busy(n);
        chk("busy_len_por", n, DEPTH);
        read_range(0, DEPTH, vc);
        chk("read_all_count", vc, DEPTH);

        // Two banks written in one cycle, read next cycle.
        wr_en = 4'b1001; wr_addr = 16'h3003; wr_data = 32'h5A0000A5;
        @(negedge clk);
        wr_en = '0; rd_en = 1'b1; rd_addr = 16'h3333;
        @(negedge clk);
        rd_en = 1'b0;
        chk("lat1_valid", rd_valid1, 1);
        chk("lat2_not_yet", rd_valid2, 0);
        @(negedge clk);
        chk("lat2_valid", rd_valid2, 1);
        chk("lat2_data", rd_data2, 32'h5A0000A5);

        // Read-first collision.
        wr_en = 4'hF; wr_addr = 16'h5555; wr_data = 32'h22222222;
        @(negedge clk);
        wr_data = 32'h11111111; rd_en = 1'b1; rd_addr = 16'h5555;
        @(negedge clk);
        wr_en = '0;
        chk("collide_old", rd_data1, 32'h22222222);
        @(negedge clk);
        rd_en = 1'b0;
        chk("collide_new", rd_data1, 32'h11111111);

        // Back-to-back reads of freshly written addresses 0..7.
        for (int a = 0; a < 8; a++) begin
            wr_en = 4'hF;
            for (int k = 0; k < NB; k++) wr_addr[k*AW +: AW] = AW'(a);
            wr_data = $urandom;
            @(negedge clk);
        end
        wr_en = '0;
        read_range(0, 8, vc);
        chk("b2b_count", vc, 8);

        // Random traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            wr_en   = NB'($urandom);
            wr_addr = (NB*AW)'($urandom);
            wr_data = $urandom;
            rd_en   = ($urandom % 4) != 0;
            rd_addr = (NB*AW)'($urandom);
            clr     = ($urandom % 64) == 0;
            @(negedge clk);
        end
        idle_inputs();
        for (int i = 0; i < 40 && busy2; i++) @(negedge clk);
        chk("random_settled", busy2, 0);

        // Clear with writes, reads and a second clr while busy.
        wr_en = 4'hF; wr_addr = 16'h7777; wr_data = 32'h77777777;
        @(negedge clk);
        wr_en = '0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            if (busy2) n++;
            else if (n > 0) break;
            wr_en = (i < 3) ? 4'hF : 4'h0; wr_addr = 16'h7777; wr_data = 32'hEEEEEEEE;
            rd_en = 1'b1; rd_addr = 16'h7777;
            clr = (i == 5);
            @(negedge clk);
        end
        idle_inputs();
        chk("busy_len_reclr", n, DEPTH);
        rd_en = 1'b1; rd_addr = 16'h7777;
        @(negedge clk);
        rd_en = 1'b0;
        chk("after_clr_valid", rd_valid1, 1);
        chk("after_clr_zero", rd_data1, 0);
        read_range(0, DEPTH, vc);

        // Reset in the middle of a clear.
        wr_en = 4'hF; wr_addr = 16'h9999; wr_data = 32'h99999999;
        @(negedge clk);
        wr_en = '0; rd_en = 1'b1; rd_addr = 16'h9999; clr = 1'b1;
        @(negedge clk);
        idle_inputs();
        repeat (5) @(negedge clk);
        chk("held_in_clear", rd_data1, 32'h99999999);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy2, 0);
        chk("mid_rst_data1", rd_data1, 0);
        chk("mid_rst_data2", rd_data2, 0);
        chk("mid_rst_valid", rd_valid2, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("busy_after_rst", busy2, 1);
        count_busy(n);
        chk("busy_len_rst", n, DEPTH);
        read_range(0, DEPTH, vc);
        chk("read_after_rst", vc, DEPTH);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

endmodule

// File: doc/ram_nbank.md
RAM_NBANK -- requirements
Module: ram_nbank

Interface
REQ-001 SHALL have parameter NBANK, default 4, number of independent banks (1..16).
REQ-002 SHALL have parameter DW, default 8, data width per bank in bits.
REQ-003 SHALL have parameter AW, default 13, address width per bank; depth = 2**AW words.
REQ-004 SHALL have parameter OUT_REG, default 1, 0 = read latency 1 cycle, 1 = read latency 2 cycles (extra output register).
REQ-005 SHALL have port clk  input  1  sole clock for all logic and memory.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port wr_en  input  NBANK  per-bank write strobe.
REQ-008 SHALL have port wr_addr  input  NBANK*AW  per-bank write address, bank k in bits [k*AW +: AW].
REQ-009 SHALL have port wr_data  input  NBANK*DW  per-bank write data, same packing.
REQ-010 SHALL have port rd_en  input  1  common read strobe for all banks.
REQ-011 SHALL have port rd_addr  input  NBANK*AW  per-bank read address.
REQ-012 SHALL have port rd_data  output  NBANK*DW  per-bank read data.
REQ-013 SHALL have port rd_valid  output  1  rd_data holds the result of an accepted read.
REQ-014 SHALL have port clr  input  1  single-cycle request to zero all banks.
REQ-015 SHALL have port busy  output  1  clear engine active; writes and reads not accepted.

Function
REQ-016 SHALL implement each bank as a simple dual-port memory: one write port, one read port, both on clk.
REQ-017 SHALL commit a write to bank k at the rising edge where wr_en[k]=1 and busy=0.
REQ-018 SHALL accept a read when rd_en=1 and busy=0; rd_valid SHALL assert exactly 1+OUT_REG cycles later for one cycle per accepted read, fully pipelined (one read per cycle).
REQ-019 SHALL hold rd_data stable when no read completes.
REQ-020 SHALL return old data (read-first) when a read and a write hit the same bank address in the same cycle.
REQ-021 SHALL run a clear state machine with states IDLE and CLEAR: IDLE->CLEAR on clr=1 or on first cycle after reset release; CLEAR writes zero to address cnt in all banks each cycle, cnt 0..2**AW-1; CLEAR->IDLE after writing address 2**AW-1.
REQ-022 SHALL assert busy for exactly 2**AW cycles per clear, from the cycle after the trigger.
REQ-023 SHALL ignore wr_en and rd_en while busy=1 (no write, no rd_valid).
REQ-024 SHALL ignore clr while busy=1 (no restart, counter not reset).
REQ-025 SHALL, when clr and wr_en coincide in IDLE, perform the write; the clear then overwrites it with zero.
REQ-026 SHALL let reads accepted before busy asserts complete normally with rd_valid.

Reset
REQ-027 SHALL on rst_n=0 asynchronously force: rd_valid=0, rd_data=0, busy=0, state=IDLE, cnt=0, read pipeline valid bits=0.
REQ-028 SHALL on rst_n=0 mid-clear abort the clear; memory contents are undefined until the automatic post-reset clear completes.
REQ-029 SHALL assert busy=1 on the first clk edge after rst_n deasserts and start the automatic clear.

Structure
REQ-030 SHALL place the state encoding (IDLE, CLEAR) and default parameter values in shared package hog_ram_pkg.
REQ-031 SHALL use one sub-module ram_nbank_bank (single SDP bank, DW x 2**AW, read-first, registered read) instantiated NBANK times via generate.
REQ-032 SHALL keep the clear counter, FSM and rd_valid pipeline in the top level, shared by all banks.

Verification
REQ-033 Reset release, AW=4 -> busy=1 for exactly 16 cycles, then 0; read all addresses -> all zero.
REQ-034 Write bank0 addr 3 = 0xA5, bank3 addr 3 = 0x5A same cycle, read addr 3 all banks next cycle, OUT_REG=1 -> rd_valid 2 cycles later, rd_data bank0=0xA5, bank3=0x5A, others 0.
REQ-035 Same-cycle write 0x11 and read, same address holding 0x22 -> read returns 0x22; following read returns 0x11.
REQ-036 Back-to-back reads of addresses 0..7 -> rd_valid high 8 consecutive cycles, data in order.
REQ-037 clr pulse, then write and rd_en during busy, then second clr during busy -> no write, no rd_valid, busy length still 2**AW, memory all zero afterwards.
REQ-038 rst_n low at clear cycle 5 -> outputs zero immediately; after release busy asserts and full clear runs.
